// File: rtl/gravador_sequencia.sv
// Records a sequence of single-button presses into a 16x4 memory with registered readback.
// Optional idle timeout in ESPERA is compiled in when the TIMEOUT_EN macro is defined.
`timescale 1ns/1ps

module gravador_sequencia #(
    parameter int LIMITE         = 16,
    parameter int TIMEOUT_CICLOS = 1000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       iniciar,
    input  logic [3:0] botoes,
    input  logic [3:0] rd_address,
    output logic [3:0] rd_data,
    output logic       gravando,
    output logic       pronto,
    output logic       erro,
    output logic [4:0] contagem,
    output logic       timeout
);

    typedef enum logic [2:0] {
        INICIAL,
        ESPERA,
        REGISTRA,
        SOLTA,
        FIM
    } estado_t;

    estado_t    estado;
    estado_t    proximo;
    logic [3:0] mem [16];
    logic [3:0] capturado;
    logic       limpa;
    logic       escreve;
    logic       captura;
    logic       erro_prox;
    logic       timeout_prox;
    logic       nenhum;
    logic       um_so;
    logic       estourou;

    assign nenhum = (botoes == 4'd0);
    assign um_so  = !nenhum && ((botoes & (botoes - 4'd1)) == 4'd0);

`ifdef TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CICLOS);

    logic [TW-1:0] ocioso;
    logic          parado;

    // Counts consecutive idle ESPERA cycles; any other cycle starts the count over.
    assign parado   = (estado == ESPERA) && !iniciar && nenhum;
    assign estourou = parado && (ocioso == TW'(TIMEOUT_CICLOS - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ocioso <= '0;
        end else if (parado && !estourou) begin
            ocioso <= ocioso + TW'(1);
        end else begin
            ocioso <= '0;
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg = (TIMEOUT_CICLOS > 1);
    assign estourou   = 1'b0;
`endif

    // iniciar overrides everything, including a pending write in REGISTRA.
    always_comb begin
        proximo      = estado;
        limpa        = 1'b0;
        escreve      = 1'b0;
        captura      = 1'b0;
        erro_prox    = 1'b0;
        timeout_prox = 1'b0;
        if (iniciar) begin
            proximo = ESPERA;
            limpa   = 1'b1;
        end else begin
            case (estado)
                INICIAL: proximo = INICIAL;
                ESPERA: begin
                    if (estourou) begin
                        proximo      = FIM;
                        timeout_prox = 1'b1;
                    end else if (um_so) begin
                        proximo = REGISTRA;
                        captura = 1'b1;
                    end else if (!nenhum) begin
                        proximo   = SOLTA;
                        erro_prox = 1'b1;
                    end
                end
                REGISTRA: begin
                    escreve = 1'b1;
                    proximo = SOLTA;
                end
                SOLTA: begin
                    if (nenhum) begin
                        proximo = (contagem == 5'(LIMITE)) ? FIM : ESPERA;
                    end
                end
                FIM:     proximo = FIM;
                default: proximo = INICIAL;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado    <= INICIAL;
            contagem  <= 5'd0;
            erro      <= 1'b0;
            timeout   <= 1'b0;
            rd_data   <= 4'd0;
            capturado <= 4'd0;
        end else begin
            estado  <= proximo;
            erro    <= erro_prox;
            timeout <= timeout_prox;
            rd_data <= mem[rd_address];
            if (captura) begin
                capturado <= botoes;
            end
            if (limpa) begin
                contagem <= 5'd0;
            end else if (escreve) begin
                contagem <= contagem + 5'd1;
            end
        end
    end

    // Memory is deliberately not reset; the read above sees pre-write contents.
    always_ff @(posedge clock) begin
        if (escreve) begin
            mem[contagem[3:0]] <= capturado;
        end
    end

    assign gravando = (estado == ESPERA) || (estado == REGISTRA) || (estado == SOLTA);
    assign pronto   = (estado == FIM);

endmodule
